// File: rtl/irs_readout_block_queue_pkg.sv
// Shared constants and types for the IRS readout block queue.
package irs_readout_block_queue_pkg;

  localparam int unsigned IRS_BLOCK_BITS = 10;
  localparam int unsigned IRS_NUM_BLOCKS = 1 << IRS_BLOCK_BITS;

  // Outcome of an acknowledged block in its ack cycle.
  typedef enum logic [1:0] {
    ACK_PUSH = 2'd0,
    ACK_DUP  = 2'd1,
    ACK_FULL = 2'd2
  } ack_action_e;

endpackage

// File: rtl/irs_block_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and synchronous flush.
module irs_block_fifo #(
  parameter int unsigned WIDTH      = 11,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign count_o = wr_ptr - rd_ptr;
  assign empty_o = (count_o == '0);
  assign full_o  = count_o[DEPTH_LOG2];

  // A pop frees the slot in the same cycle, so push is legal on a full queue when popping.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head is gated to zero while empty so the output reads 0 out of reset and after flush.
  assign dout_o  = empty_o ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din_i;
  end

endmodule

// File: rtl/irs_readout_block_queue.sv
// Readout queue behind the IRS history buffer: drops blocks already queued or in digitization,
// tracks busy blocks in a bitmap cleared only by digitizer completion.
module irs_readout_block_queue
  import irs_readout_block_queue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned BLOCK_BITS = IRS_BLOCK_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [BLOCK_BITS-1:0] block_i,
  input  logic                  block_ack_i,
  input  logic                  event_start_i,
  output logic [BLOCK_BITS-1:0] rd_block_o,
  output logic                  rd_event_start_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  input  logic                  done_i,
  input  logic [BLOCK_BITS-1:0] done_block_i,
  input  logic                  flush_i,
  output logic                  dup_o,
  output logic                  overflow_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned NUM_BLOCKS = 1 << BLOCK_BITS;

  logic [NUM_BLOCKS-1:0] busy;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic                  clr_hit;
  logic                  busy_now;
  ack_action_e           action;

  assign pop = rd_valid_o & rd_ready_i;

  // A done for the same block in the ack cycle clears first, so the ack sees it idle.
  assign clr_hit  = done_i & (done_block_i == block_i);
  assign busy_now = busy[block_i] & ~clr_hit;

  always_comb begin
    action = ACK_PUSH;
    if (busy_now)              action = ACK_DUP;
    else if (fifo_full && !pop) action = ACK_FULL;
  end

  assign push = block_ack_i & ~flush_i & (action == ACK_PUSH);

  irs_block_fifo #(
    .WIDTH      (BLOCK_BITS + 1),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .push_i  (push),
    .din_i   ({event_start_i, block_i}),
    .pop_i   (pop),
    .dout_o  ({rd_event_start_o, rd_block_o}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign rd_valid_o = ~fifo_empty;

  // Set follows clear so a same-cycle done+push of one block leaves it busy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy <= '0;
    end else if (flush_i) begin
      busy <= '0;
    end else begin
      if (done_i) busy[done_block_i] <= 1'b0;
      if (push)   busy[block_i]      <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dup_o      <= 1'b0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      dup_o      <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      dup_o <= block_ack_i & (action == ACK_DUP);
      if (block_ack_i && action == ACK_FULL) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irs_readout_block_queue.sv
// Directed self-checking bench for irs_readout_block_queue.
module tb_irs_readout_block_queue;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [9:0] block_i = '0;
  logic       block_ack_i = 1'b0;
  logic       event_start_i = 1'b0;
  logic [9:0] rd_block_o;
  logic       rd_event_start_o;
  logic       rd_valid_o;
  logic       rd_ready_i = 1'b0;
  logic       done_i = 1'b0;
  logic [9:0] done_block_i = '0;
  logic       flush_i = 1'b0;
  logic       dup_o;
  logic       overflow_o;
  logic [4:0] count_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  irs_readout_block_queue #(
    .DEPTH_LOG2 (4),
    .BLOCK_BITS (10)
  ) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .block_i          (block_i),
    .block_ack_i      (block_ack_i),
    .event_start_i    (event_start_i),
    .rd_block_o       (rd_block_o),
    .rd_event_start_o (rd_event_start_o),
    .rd_valid_o       (rd_valid_o),
    .rd_ready_i       (rd_ready_i),
    .done_i           (done_i),
    .done_block_i     (done_block_i),
    .flush_i          (flush_i),
    .dup_o            (dup_o),
    .overflow_o       (overflow_o),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge, strobes are then dropped.
  task automatic cyc();
    @(posedge clk_i);
    #1;
    block_ack_i   = 1'b0;
    event_start_i = 1'b0;
    done_i        = 1'b0;
    flush_i       = 1'b0;
    rd_ready_i    = 1'b0;
  endtask

  task automatic ack(input logic [9:0] b, input logic es);
    block_i       = b;
    event_start_i = es;
    block_ack_i   = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", rd_valid_o, 0);
    check("rst_block", rd_block_o, 0);
    check("rst_es", rd_event_start_o, 0);
    check("rst_dup", dup_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_count", count_o, 0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    cyc();

    // 1: first ack into empty queue
    ack(10'h005, 1'b1); cyc();
    check("t1_valid", rd_valid_o, 1);
    check("t1_block", rd_block_o, 10'h005);
    check("t1_es", rd_event_start_o, 1);
    check("t1_count", count_o, 1);
    rd_ready_i = 1'b1; cyc();
    check("t1_pop_count", count_o, 0);
    check("t1_pop_valid", rd_valid_o, 0);
    ack(10'h005, 1'b0); cyc();
    check("t1_busy_after_pop", dup_o, 1);
    check("t1_dup_count", count_o, 0);

    // 2: duplicate suppression until done
    ack(10'h010, 1'b0); cyc();
    check("t2_first_dup", dup_o, 0);
    ack(10'h010, 1'b0); cyc();
    check("t2_dup", dup_o, 1);
    check("t2_count", count_o, 1);
    cyc();
    check("t2_dup_pulse", dup_o, 0);
    rd_ready_i = 1'b1; cyc();
    check("t2_pop", count_o, 0);
    ack(10'h010, 1'b0); cyc();
    check("t2_dup_after_pop", dup_o, 1);
    done_i = 1'b1; done_block_i = 10'h010; cyc();
    ack(10'h010, 1'b0); cyc();
    check("t2_done_dup", dup_o, 0);
    check("t2_done_count", count_o, 1);
    check("t2_done_block", rd_block_o, 10'h010);

    // 3: overflow on the 17th distinct ack
    flush_i = 1'b1; cyc();
    for (int i = 0; i < 17; i++) begin
      ack(10'h100 + 10'(i), 1'b0); cyc();
    end
    check("t3_count", count_o, 16);
    check("t3_ovf", overflow_o, 1);
    check("t3_head", rd_block_o, 10'h100);
    rd_ready_i = 1'b1; cyc();
    check("t3_pop_count", count_o, 15);
    ack(10'h110, 1'b0); cyc();
    check("t3_reack_dup", dup_o, 0);
    check("t3_reack_count", count_o, 16);
    ack(10'h100, 1'b0); cyc();
    check("t3_popped_busy", dup_o, 1);

    // 4: full queue with simultaneous pop accepts the ack
    flush_i = 1'b1; cyc();
    check("t4_flush_ovf", overflow_o, 0);
    check("t4_flush_count", count_o, 0);
    for (int i = 0; i < 16; i++) begin
      ack(10'h200 + 10'(i), 1'b0); cyc();
    end
    check("t4_full", count_o, 16);
    ack(10'h3FF, 1'b1); rd_ready_i = 1'b1; cyc();
    check("t4_count", count_o, 16);
    check("t4_ovf", overflow_o, 0);
    check("t4_dup", dup_o, 0);
    check("t4_head", rd_block_o, 10'h201);
    for (int i = 0; i < 15; i++) begin
      rd_ready_i = 1'b1; cyc();
    end
    check("t4_tail_count", count_o, 1);
    check("t4_tail_block", rd_block_o, 10'h3FF);
    check("t4_tail_es", rd_event_start_o, 1);
    check("t4_stable", rd_block_o, 10'h3FF);

    // 5: same-cycle ack and done of the same busy block
    flush_i = 1'b1; cyc();
    ack(10'h123, 1'b0); cyc();
    rd_ready_i = 1'b1; cyc();
    check("t5_empty", count_o, 0);
    ack(10'h123, 1'b0); done_i = 1'b1; done_block_i = 10'h123; cyc();
    check("t5_dup", dup_o, 0);
    check("t5_count", count_o, 1);
    ack(10'h123, 1'b0); cyc();
    check("t5_still_busy", dup_o, 1);
    done_i = 1'b1; done_block_i = 10'h2AA; cyc();
    check("t5_idle_done", count_o, 1);
    ack(10'h0AB, 1'b0); rd_ready_i = 1'b1; cyc();
    check("t5_pp_valid", rd_valid_o, 1);
    check("t5_pp_block", rd_block_o, 10'h0AB);
    check("t5_pp_count", count_o, 1);

    // 6: async reset mid-cycle, then flush with 5 queued
    flush_i = 1'b1; cyc();
    for (int i = 0; i < 5; i++) begin
      ack(10'h040 + 10'(i), 1'b1); cyc();
    end
    check("t6_pre_count", count_o, 5);
    #2 rst_n_i = 1'b0;
    #1;
    check("t6_rst_valid", rd_valid_o, 0);
    check("t6_rst_count", count_o, 0);
    check("t6_rst_block", rd_block_o, 0);
    check("t6_rst_es", rd_event_start_o, 0);
    #2 rst_n_i = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      ack(10'h040 + 10'(i), 1'b0); cyc();
    end
    check("t6_reack_count", count_o, 5);
    check("t6_reack_dup", dup_o, 0);
    flush_i = 1'b1; ack(10'h050, 1'b0); done_i = 1'b1; done_block_i = 10'h040; cyc();
    check("t6_flush_valid", rd_valid_o, 0);
    check("t6_flush_count", count_o, 0);
    check("t6_flush_ovf", overflow_o, 0);
    ack(10'h050, 1'b0); cyc();
    check("t6_ignored_ack", dup_o, 0);
    check("t6_ignored_count", count_o, 1);
    ack(10'h040, 1'b0); cyc();
    check("t6_reackable", dup_o, 0);
    check("t6_final_count", count_o, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
